io_read_arbiter: RTL
====================

Name: io_read_arbiter

Overview:
- Shares one Scalar A/B I/O read port (word, EF, rden triple) among REQ_COUNT external requesters, such as accelerators or SIMD-side producers.
- Uses fair round-robin arbitration into a 2-entry output buffer.
- The buffer sustains one word per cycle, so barrel-threaded rden pulses on consecutive cycles from different threads are served without stalls.
- Sits between external producers and the Scalar io_in, io_in_EF and io_rden bus for one port slot.

Parameters:
- WORD_WIDTH, 36, data word width; matches A_WORD_WIDTH or B_WORD_WIDTH.
- REQ_COUNT, 4, number of requesters; minimum 2.
- REQ_ID_WIDTH, 2, width of requester index; must equal clog2(REQ_COUNT).
- UNDERRUN_WIDTH, 8, width of the saturating underrun counter.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, REQ_COUNT, requester i has a word to offer.
- req_ready, output, REQ_COUNT, one-hot grant; a word transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
- req_data, input, WORD_WIDTH*REQ_COUNT, flat vector; requester i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- io_in, output, WORD_WIDTH, head-of-buffer word presented to the CPU read port.
- io_in_EF, output, 1, high when io_in holds a valid word.
- io_rden, input, 1, CPU consume strobe for the head word.
- underrun_count, output, UNDERRUN_WIDTH, count of io_rden pulses that arrived while io_in_EF was 0.

Behaviour:
- Reset (async assert, sync release):
  - buffer count = 0; io_in = 0; io_in_EF = 0; underrun_count = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready = 0 for the whole time reset_n is low.
  - Reset mid-operation discards all buffered words; no partial transfer survives.
- Space:
  - space = (count < 2). Registered count only; there is no combinational path from io_rden to req_ready.
- Grant (combinational from req_valid, pointer and count):
  - If space, req_ready asserts for the first i with req_valid[i] high, searching from pointer upward and wrapping modulo REQ_COUNT.
  - At most one bit of req_ready is high. All bits are 0 when there is no space or no valid request.
  - req_ready never asserts without the matching req_valid.
- Pointer update:
  - On a transfer from requester g, pointer becomes (g+1) mod REQ_COUNT.
  - With no transfer, the pointer holds.
  - Wrap-around: g = REQ_COUNT-1 sets the pointer to 0.
- Push (transfer) at edge N:
  - req_data slice g is written to the tail.
  - The word appears on io_in at N+1 if the buffer was empty, or was at count 1 with a pop at N.
  - io_in_EF rises at N+1. Latency from grant to visibility is 1 cycle.
- Pop:
  - io_rden high with io_in_EF high at edge N retires the head.
  - The second entry, if present, moves to io_in at N+1.
- Simultaneous push and pop:
  - count 1: count stays 1, and the new word becomes head at N+1.
  - count 2: no push is possible; count becomes 1.
- Underrun:
  - io_rden while io_in_EF = 0 has no data effect.
  - underrun_count increments by 1, saturating at all-ones.
  - A push in the same cycle proceeds normally.
- Ordering: words leave in acceptance order.
- No word is duplicated or dropped except on reset.
- io_in holds its last value while io_in_EF = 0; contents are don't-care but stable.

Optional Feature:
- Macro: IO_READ_ARBITER_TAG_EN.
- When defined:
  - Adds output port io_in_tag, REQ_ID_WIDTH bits.
  - It is stored alongside each buffer entry and gives the requester index of the word currently on io_in.
  - It is intended to feed a second read port slot so software can identify the source.
  - Reset value is 0. It updates exactly when io_in updates.
- When undefined:
  - The port is absent and there is no tag storage.
  - All other behaviour is identical.

Test Plan:
- Reset, then hold all req_valid=0 and pulse io_rden 3 times.
  - Expect io_in_EF=0, req_ready=0 throughout, and underrun_count=3.
- Hold req_valid=4'b1111 with data 10,11,12,13 and io_rden tied high.
  - Expect grants in order 0,1,2,3,0 with one grant per cycle.
  - Expect io_in to show 10,11,12,13,10 on consecutive cycles, each 1 cycle after its grant.
- Hold req_valid=4'b0100 and io_rden=0.
  - Expect 2 transfers from requester 2, then req_ready=0 with count=2.
  - Pulse io_rden once; expect req_ready[2]=1 on the following cycle.
- Pointer wrap: grant requester 3 with value 0x3, then raise req_valid=4'b1001.
  - Expect requester 0 granted next, then 3.
  - With IO_READ_ARBITER_TAG_EN, expect io_in_tag to follow 3,0,3.
- Assert reset_n=0 mid-stream with count=2.
  - Expect io_in_EF=0, io_in=0 and req_ready=0 immediately (async).
  - After release, the first grant goes to the lowest-index valid requester.
- Set underrun_count to saturation: drive 300 empty io_rden pulses with UNDERRUN_WIDTH=8.
  - Expect underrun_count=255.

Source files
------------

// File: rtl/io_read_arbiter_if.sv
// io_read_arbiter_if: requester handshake plus CPU read-port bundle for io_read_arbiter.
// The io_in_tag signal exists only when IO_READ_ARBITER_TAG_EN is defined.
interface io_read_arbiter_if #(
  parameter int WORD_WIDTH     = 36,
  parameter int REQ_COUNT      = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int UNDERRUN_WIDTH = 8
);
  logic [REQ_COUNT-1:0]            req_valid;
  logic [REQ_COUNT-1:0]            req_ready;
  logic [WORD_WIDTH*REQ_COUNT-1:0] req_data;
  logic [WORD_WIDTH-1:0]           io_in;
  logic                            io_in_EF;
  logic                            io_rden;
  logic [UNDERRUN_WIDTH-1:0]       underrun_count;
`ifdef IO_READ_ARBITER_TAG_EN
  logic [REQ_ID_WIDTH-1:0]         io_in_tag;
  modport slave (input req_valid, req_data, io_rden,
                 output req_ready, io_in, io_in_EF, underrun_count, io_in_tag);
  modport master (output req_valid, req_data, io_rden,
                  input req_ready, io_in, io_in_EF, underrun_count, io_in_tag);
`else
  modport slave (input req_valid, req_data, io_rden,
                 output req_ready, io_in, io_in_EF, underrun_count);
  modport master (output req_valid, req_data, io_rden,
                  input req_ready, io_in, io_in_EF, underrun_count);
`endif
endinterface

// File: rtl/io_read_arbiter.sv
// io_read_arbiter: round-robin arbiter feeding a 2-entry buffer on one CPU read port.
// Optional IO_READ_ARBITER_TAG_EN adds io_in_tag, the source requester of the head word.
module io_read_arbiter #(
  parameter int WORD_WIDTH     = 36,
  parameter int REQ_COUNT      = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int UNDERRUN_WIDTH = 8
) (
  input logic             clock,
  input logic             reset_n,
  io_read_arbiter_if.slave bus
);
  logic [1:0]                count;
  logic [REQ_ID_WIDTH-1:0]   ptr, gidx;
  logic [REQ_COUNT-1:0]      grant;
  logic                      found, space, push, pop, head_load, second_load;
  logic [WORD_WIDTH-1:0]     head, second, wdata;
  logic [UNDERRUN_WIDTH-1:0] underrun;
  int                        j;
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      j = (int'(ptr) + k) % REQ_COUNT;
      if (!found && bus.req_valid[j]) begin
        grant[j] = 1'b1;
        gidx     = REQ_ID_WIDTH'(j);
        found    = 1'b1;
      end
    end
  end
  // Space comes from the registered count only, so io_rden never reaches req_ready.
  assign space         = count != 2'd2;
  assign bus.req_ready = (space && reset_n) ? grant : '0;
  assign push          = |(bus.req_valid & bus.req_ready);
  assign pop           = bus.io_rden && bus.io_in_EF;
  assign wdata         = bus.req_data[gidx*WORD_WIDTH +: WORD_WIDTH];
  assign head_load     = (push && (count == 2'd0 || (count == 2'd1 && pop))) || (pop && count == 2'd2);
  assign second_load   = push && count == 2'd1 && !pop;
  assign bus.io_in     = head;
  assign bus.io_in_EF  = count != 2'd0;
  assign bus.underrun_count = underrun;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      ptr      <= '0;
      head     <= '0;
      second   <= '0;
      underrun <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) ptr <= REQ_ID_WIDTH'((int'(gidx) + 1) % REQ_COUNT);
      if (head_load) head <= (count == 2'd2) ? second : wdata;
      if (second_load) second <= wdata;
      if (bus.io_rden && !bus.io_in_EF && !(&underrun)) underrun <= underrun + 1'b1;
    end
  end
`ifdef IO_READ_ARBITER_TAG_EN
  logic [REQ_ID_WIDTH-1:0] head_tag, second_tag;
  assign bus.io_in_tag = head_tag;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_tag   <= '0;
      second_tag <= '0;
    end else begin
      if (head_load) head_tag <= (count == 2'd2) ? second_tag : gidx;
      if (second_load) second_tag <= gidx;
    end
  end
`endif
endmodule
